mipi_multi_lane_distributor: RTL

TX-side counterpart of the multi-lane aligner. It takes a serial byte stream of one DSI packet per s_last-terminated burst and buffers the whole packet (store-and-forward). It then drives it onto LANES parallel byte lanes round-robin, so byte n goes to lane n mod LANES, with no HS underflow. Per-lane valids deassert independently at end of packet, as in D-PHY EoT. It feeds the lane serialisers and closes the loop with the aligner in lane-level loopback benches.

---
 rtl/mipi_dphy_pkg.sv | 29 ++
 rtl/mipi_lane_bank_ram.sv | 47 ++++
 rtl/mipi_multi_lane_distributor.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mipi_dphy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mipi_dphy_pkg
// Description : Shared types and helpers for the multi-lane D-PHY byte
//               distributor: FSM state encoding, the default sync byte
//               value and a width helper for length/row counters.
// Revision    : 1.0 - initial release
// ============================================================================
package mipi_dphy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_DROP = 3'd2,
    ST_SYNC = 3'd3,
    ST_DATA = 3'd4,
    ST_GAP  = 3'd5
  } state_t;

  localparam logic [7:0] c_default_sync_byte = 8'hB8;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int calc_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mipi_lane_bank_ram.sv
`default_nettype none
// ============================================================================
// Module      : mipi_lane_bank_ram
// Description : One byte-wide packet buffer bank. Simple dual port: one
//               write port, one registered read port. A read of the address
//               being written in the same cycle returns the new byte, so the
//               last byte of a packet is visible to the first output beat.
// Ports       : clk      - clock
//               i_we     - write enable
//               i_waddr  - write row
//               i_wdata  - write byte
//               i_raddr  - read row (sampled on clk)
//               o_rdata  - registered read byte
// Revision    : 1.0 - initial release
// ============================================================================
module mipi_lane_bank_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    // Write-first bypass: the closing byte of a short packet lands in the
    // same row the first beat is being read from.
    if (i_we && (i_waddr == i_raddr)) begin
      r_rdata <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mipi_multi_lane_distributor.sv
`default_nettype none
// ============================================================================
// Module      : mipi_multi_lane_distributor
// Description : Store-and-forward byte-to-lane distributor. Buffers one
//               s_last-terminated packet, then emits it round-robin over
//               LANES byte lanes (byte n on lane n mod LANES) without
//               bubbles, optionally preceded by a sync beat and always
//               followed by GAP_CYCLES idle cycles.
// Ports       : byte_clk             - clock, all logic on rising edge
//               sys_rst              - synchronous active-high reset
//               s_data/s_valid/s_last/s_ready - byte input stream
//               lanes_data_out_valid - per-lane valid, bit i = lane i
//               lanes_data_out       - lane i at [8i+7:8i]
//               busy                 - high in SYNC/DATA/GAP
//               overflow             - one-cycle pulse on oversize packet
// Revision    : 1.0 - initial release
// ============================================================================
module mipi_multi_lane_distributor
  import mipi_dphy_pkg::*;
#(
  parameter int         LANES       = 4,
  parameter int         BUF_DEPTH   = 256,
  parameter int         GAP_CYCLES  = 10,
  parameter int         INSERT_SYNC = 0,
  parameter logic [7:0] SYNC_BYTE   = c_default_sync_byte
) (
  input  logic               byte_clk,
  input  logic               sys_rst,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [LANES-1:0]   lanes_data_out_valid,
  output logic [LANES*8-1:0] lanes_data_out,
  output logic               busy,
  output logic               overflow
);

  localparam int c_rows   = BUF_DEPTH / LANES;
  localparam int c_cnt_w  = calc_width(BUF_DEPTH + 1);
  localparam int c_row_w  = calc_width(c_rows);
  localparam int c_rrow_w = calc_width(c_rows + 1);
  localparam int c_bank_w = calc_width(LANES);
  localparam int c_gap_w  = calc_width(GAP_CYCLES + 1);

  localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(BUF_DEPTH);
  localparam logic [c_cnt_w-1:0]  c_lanes     = c_cnt_w'(LANES);
  localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
  localparam logic [c_row_w-1:0]  c_row_one   = c_row_w'(1);
  localparam logic [c_rrow_w-1:0] c_rrow_one  = c_rrow_w'(1);
  localparam logic [c_rrow_w-1:0] c_rrow_lim  = c_rrow_w'(c_rows);
  localparam logic [c_bank_w-1:0] c_bank_one  = c_bank_w'(1);
  localparam logic [c_bank_w-1:0] c_bank_last = c_bank_w'(LANES - 1);
  localparam logic [c_gap_w-1:0]  c_gap_one   = c_gap_w'(1);
  localparam logic [c_gap_w-1:0]  c_gap_last  = c_gap_w'(GAP_CYCLES - 1);

  state_t               r_state;
  state_t               w_next;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_bank_w-1:0]  r_bank;
  logic [c_row_w-1:0]   r_row;
  logic [c_cnt_w-1:0]   r_rem;      // bytes not yet emitted, incl. current beat
  logic [c_rrow_w-1:0]  r_rd_row;   // row to be read on the next edge
  logic [c_gap_w-1:0]   r_gap;
  logic [LANES-1:0]     r_valid;
  logic                 r_sync;
  logic                 r_overflow;

  logic                 w_accept;
  logic                 w_we;
  logic                 w_full;
  logic                 w_last_beat;
  logic                 w_gap_done;
  logic [c_row_w-1:0]   w_raddr;
  logic [7:0]           w_rdata [LANES];

  // Lanes carrying a real byte for a beat that still has n bytes to go.
  function automatic logic [LANES-1:0] lane_mask(input logic [c_cnt_w-1:0] n);
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      m[i] = (c_cnt_w'(i) < n);
    end
    return m;
  endfunction

  assign w_accept    = s_valid && s_ready;
  assign w_full      = (r_cnt == c_depth);
  assign w_we        = w_accept && ((r_state == ST_IDLE) || (r_state == ST_FILL)) && !w_full;
  assign w_last_beat = (r_rem <= c_lanes);
  assign w_gap_done  = (r_gap == c_gap_last);
  // Past the final row only happens while the last beat is on the lanes;
  // that read result is never used, so park the address at row 0.
  assign w_raddr     = (r_rd_row < c_rrow_lim) ? r_rd_row[c_row_w-1:0] : '0;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge byte_clk) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next  = r_state;
    s_ready = 1'b0;
    busy    = 1'b0;
    case (r_state)
      ST_IDLE, ST_FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (w_full) begin
            w_next = s_last ? ST_IDLE : ST_DROP;
          end else if (s_last) begin
            w_next = (INSERT_SYNC != 0) ? ST_SYNC : ST_DATA;
          end else begin
            w_next = ST_FILL;
          end
        end
      end
      ST_DROP: begin
        s_ready = 1'b1;
        if (s_valid && s_last) begin
          w_next = ST_IDLE;
        end
      end
      ST_SYNC: begin
        busy   = 1'b1;
        w_next = ST_DATA;
      end
      ST_DATA: begin
        busy = 1'b1;
        if (w_last_beat) begin
          w_next = ST_GAP;
        end
      end
      ST_GAP: begin
        busy = 1'b1;
        if (w_gap_done) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Counters, read prefetch and per-beat valid mask
  // --------------------------------------------------------------------------
  always_ff @(posedge byte_clk) begin
    if (sys_rst) begin
      r_cnt      <= '0;
      r_bank     <= '0;
      r_row      <= '0;
      r_rem      <= '0;
      r_rd_row   <= '0;
      r_gap      <= '0;
      r_valid    <= '0;
      r_sync     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      case (r_state)
        ST_IDLE, ST_FILL: begin
          if (w_accept) begin
            if (w_full) begin
              r_overflow <= 1'b1;
              r_cnt      <= '0;
              r_bank     <= '0;
              r_row      <= '0;
            end else if (s_last) begin
              r_cnt  <= '0;
              r_bank <= '0;
              r_row  <= '0;
              r_rem  <= r_cnt + c_cnt_one;
              if (INSERT_SYNC != 0) begin
                r_sync  <= 1'b1;
                r_valid <= '1;
              end else begin
                // Row 0 is read on this very edge, so beat 0 is ready next cycle.
                r_valid  <= lane_mask(r_cnt + c_cnt_one);
                r_rd_row <= c_rrow_one;
              end
            end else begin
              r_cnt <= r_cnt + c_cnt_one;
              if (r_bank == c_bank_last) begin
                r_bank <= '0;
                r_row  <= r_row + c_row_one;
              end else begin
                r_bank <= r_bank + c_bank_one;
              end
            end
          end
        end
        ST_SYNC: begin
          r_sync   <= 1'b0;
          r_valid  <= lane_mask(r_rem);
          r_rd_row <= c_rrow_one;
        end
        ST_DATA: begin
          if (w_last_beat) begin
            r_valid  <= '0;
            r_rem    <= '0;
            r_rd_row <= '0;
            r_gap    <= '0;
          end else begin
            r_rem    <= r_rem - c_lanes;
            r_valid  <= lane_mask(r_rem - c_lanes);
            r_rd_row <= r_rd_row + c_rrow_one;
          end
        end
        ST_GAP: begin
          r_gap <= r_gap + c_gap_one;
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Lane banks and output muxing
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mipi_lane_bank_ram #(
      .DEPTH (c_rows),
      .AW    (c_row_w)
    ) u_bank (
      .clk     (byte_clk),
      .i_we    (w_we && (r_bank == c_bank_w'(g))),
      .i_waddr (r_row),
      .i_wdata (s_data),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata[g])
    );

    assign lanes_data_out[8*g +: 8] = r_sync     ? SYNC_BYTE  :
                                      r_valid[g] ? w_rdata[g] : 8'h00;
  end

  assign lanes_data_out_valid = r_valid;
  assign overflow             = r_overflow;

endmodule
`default_nettype wire
